scoreboard: RTL and testbench
=============================

// Module: scoreboard
// PURPOSE
//   Register-busy scoreboard for the decode stage. Tracks in-flight writes to
//   each architectural integer register and drives the bubble1/bubble2 hazard
//   inputs of the decode operand/immediate selector for rs1/rs2. Issue updates
//   come from the decode->execute handoff; clears come from writeback.
//   Also gates issue when a register's pending-write counter is saturated.
// PARAMETERS
//   NREG       32  architectural registers; index 0 is hardwired zero
//   CNT_W      2   per-register pending counter width; MAX_PEND = 2**CNT_W-1
//   BYPASS_WB  1   1: same-cycle writeback of the last pending write clears bubble
// PORTS
//   clk          in   1        clock, rising edge
//   reset        in   1        asynchronous, active-low reset
//   rs1          in   5        decode source register 1 index
//   rs2          in   5        decode source register 2 index
//   issue_valid  in   1        decode instruction leaves decode this cycle
//   issue_wen    in   1        issuing instruction writes rd
//   issue_rd     in   5        issuing instruction destination index
//   issue_ready  out  1        0 = counter[issue_rd] saturated; decode must hold
//   wb_valid     in   1        writeback retires a register write this cycle
//   wb_rd        in   5        writeback destination index
//   flush        in   1        pipeline squash; clears all pending state
//   bubble1      out  1        rs1 has a pending write (combinational)
//   bubble2      out  1        rs2 has a pending write (combinational)
//   n_busy       out  6        number of registers with nonzero counter
//   sb_err       out  1        sticky: writeback to a register with counter 0
// BEHAVIOUR
//   - State: cnt[1..NREG-1], CNT_W bits each; cnt[0] does not exist (reads 0).
//   - reset low (async): all cnt=0, sb_err=0; outputs then bubble1=bubble2=0,
//     issue_ready=1, n_busy=0. Reset mid-operation discards all pending state.
//   - issue_ready = (issue_rd==0) | ~issue_wen | (cnt[issue_rd]!=MAX_PEND).
//   - Issue accepted at edge when issue_valid & issue_wen & issue_ready &
//     issue_rd!=0: cnt[issue_rd]+=1. issue_valid with issue_ready=0 is ignored.
//   - Writeback at edge when wb_valid & wb_rd!=0: cnt[wb_rd]-=1 if nonzero;
//     if cnt[wb_rd]==0 counter stays 0 and sb_err sets (held until reset).
//   - Accepted issue and writeback to same rd in one cycle: cnt unchanged
//     (no sb_err even if cnt==0, the issue covers the retire).
//   - busy(r) = (r!=0) & (cnt[r]!=0) & ~(BYPASS_WB & wb_valid & wb_rd==r &
//     cnt[r]==1). bubble1=busy(rs1), bubble2=busy(rs2), zero-cycle lookup.
//   - Latency: accepted issue at edge t -> bubble visible in cycle after t;
//     no same-cycle issue->bubble forwarding (decode of the issuing instruction
//     never depends on itself).
//   - flush at edge: all cnt=0; issue and writeback in that cycle are ignored;
//     sb_err unaffected. Upstream guarantees squashed writes never write back.
//   - n_busy: registered popcount of nonzero cnt, updated at the same edge as
//     cnt (reflects post-edge state); reset 0.
//   - Counters never wrap: increment blocked at MAX_PEND, decrement at 0.
// TESTING
//   - Reset: hold reset=0 with random inputs -> bubble1/2=0, issue_ready=1,
//     n_busy=0, sb_err=0; release, rs1=rs2=0 -> bubbles 0.
//   - Issue rd=5, next cycle rs1=5 -> bubble1=1, n_busy=1; wb_rd=5 with
//     BYPASS_WB=1 -> bubble1=0 same cycle, cnt[5]=0, n_busy=0 after edge.
//   - Issue rd=0 three times -> no state change, rs2=0 bubble2=0, issue_ready=1.
//   - Three issues to rd=7 -> cnt=3, issue_ready=0 for rd=7; fourth issue ignored;
//     three writebacks -> bubble for rs1=7 clears only after the third.
//   - cnt[9]=1; same cycle issue rd=9 and wb rd=9 -> cnt stays 1, bubble persists;
//     wb rd=12 with cnt 0 -> sb_err=1, stays 1 across flush.
//   - Regs 3,4 busy, flush with simultaneous issue rd=6 -> all cnt 0, n_busy=0.

Source files
------------

// File: rtl/scoreboard_if.sv
// Decode/writeback side of the register-busy scoreboard.
//
// Handshake: an issue is taken at a rising edge when issue_valid, issue_wen
// and issue_ready are all high and issue_rd is nonzero. A writeback is taken
// whenever wb_valid is high with nonzero wb_rd; writeback has no back-pressure.
// issue_ready depends only on issue_wen/issue_rd and the stored counters, never
// on issue_valid, so a driver may hold valid and wait for ready.
interface scoreboard_if;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       issue_valid;
    logic       issue_wen;
    logic [4:0] issue_rd;
    logic       issue_ready;
    logic       wb_valid;
    logic [4:0] wb_rd;
    logic       flush;
    logic       bubble1;
    logic       bubble2;
    logic [5:0] n_busy;
    logic       sb_err;

    // Decode / writeback / squash logic drives the requests and reads the hazards.
    modport master (
        output rs1, rs2, issue_valid, issue_wen, issue_rd, wb_valid, wb_rd, flush,
        input  issue_ready, bubble1, bubble2, n_busy, sb_err
    );

    // The scoreboard itself.
    modport slave (
        input  rs1, rs2, issue_valid, issue_wen, issue_rd, wb_valid, wb_rd, flush,
        output issue_ready, bubble1, bubble2, n_busy, sb_err
    );
endinterface

// File: rtl/scoreboard.sv
// Register-busy scoreboard: one saturating pending-write counter per integer
// register, combinational rs1/rs2 hazard lookup, issue gating on saturation,
// registered busy-register count and a sticky underflow error flag.
module scoreboard #(
    parameter int NREG      = 32,
    parameter int CNT_W     = 2,
    parameter bit BYPASS_WB = 1'b1
) (
    input logic         clk,
    input logic         reset,
    scoreboard_if.slave sb
);
    localparam logic [CNT_W-1:0] MAX_PEND = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;

    // Entry 0 is kept at zero permanently so x0 never reads as busy.
    logic [CNT_W-1:0] cnt_q [NREG];
    logic [CNT_W-1:0] cnt_d [NREG];
    logic             sb_err_q;
    logic             sb_err_d;
    logic [5:0]       n_busy_q;
    logic [5:0]       n_busy_d;

    logic             issue_ready;
    logic             issue_acc;
    logic             wb_act;
    logic             same_rd;
    logic [CNT_W-1:0] cnt_rs1;
    logic [CNT_W-1:0] cnt_rs2;

    // Issue gating and accepted-event decode.
    always_comb begin
        issue_ready = (sb.issue_rd == 5'd0) | ~sb.issue_wen
                      | (cnt_q[sb.issue_rd] != MAX_PEND);
        issue_acc   = sb.issue_valid & sb.issue_wen & issue_ready & (sb.issue_rd != 5'd0);
        wb_act      = sb.wb_valid & (sb.wb_rd != 5'd0);
        same_rd     = issue_acc & wb_act & (sb.issue_rd == sb.wb_rd);
    end

    // Next counter state, error flag and busy-register count.
    always_comb begin
        cnt_d    = cnt_q;
        sb_err_d = sb_err_q;
        n_busy_d = '0;
        if (sb.flush) begin
            // Squash drops every pending write; same-cycle events are ignored.
            for (int r = 0; r < NREG; r++) begin
                cnt_d[r] = CNT_ZERO;
            end
        end else if (!same_rd) begin
            // An issue and retire to the same rd cancel out, so only act when they differ.
            if (issue_acc) begin
                cnt_d[sb.issue_rd] = cnt_q[sb.issue_rd] + CNT_ONE;
            end
            if (wb_act) begin
                if (cnt_q[sb.wb_rd] != CNT_ZERO) begin
                    cnt_d[sb.wb_rd] = cnt_q[sb.wb_rd] - CNT_ONE;
                end else begin
                    sb_err_d = 1'b1;
                end
            end
        end
        cnt_d[0] = CNT_ZERO;
        for (int r = 1; r < NREG; r++) begin
            n_busy_d = n_busy_d + {5'd0, (cnt_d[r] != CNT_ZERO)};
        end
    end

    // State registers; reset discards all pending writes and the error flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < NREG; r++) begin
                cnt_q[r] <= CNT_ZERO;
            end
            sb_err_q <= 1'b0;
            n_busy_q <= '0;
        end else begin
            for (int r = 0; r < NREG; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
            sb_err_q <= sb_err_d;
            n_busy_q <= n_busy_d;
        end
    end

    // Zero-cycle hazard lookup; a retire of the last pending write bypasses the bubble.
    always_comb begin
        cnt_rs1    = cnt_q[sb.rs1];
        cnt_rs2    = cnt_q[sb.rs2];
        sb.bubble1 = (sb.rs1 != 5'd0) & (cnt_rs1 != CNT_ZERO)
                     & ~(BYPASS_WB & sb.wb_valid & (sb.wb_rd == sb.rs1) & (cnt_rs1 == CNT_ONE));
        sb.bubble2 = (sb.rs2 != 5'd0) & (cnt_rs2 != CNT_ZERO)
                     & ~(BYPASS_WB & sb.wb_valid & (sb.wb_rd == sb.rs2) & (cnt_rs2 == CNT_ONE));
    end

    assign sb.issue_ready = issue_ready;
    assign sb.n_busy      = n_busy_q;
    assign sb.sb_err      = sb_err_q;
endmodule

// File: tb/tb_scoreboard.sv
// Directed bench for the register-busy scoreboard.
module tb_scoreboard;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    scoreboard_if sb_if ();

    scoreboard dut (
        .clk   (clk),
        .reset (reset),
        .sb    (sb_if)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver tasks: inputs change 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        sb_if.rs1         = 5'd0;
        sb_if.rs2         = 5'd0;
        sb_if.issue_valid = 1'b0;
        sb_if.issue_wen   = 1'b0;
        sb_if.issue_rd    = 5'd0;
        sb_if.wb_valid    = 1'b0;
        sb_if.wb_rd       = 5'd0;
        sb_if.flush       = 1'b0;
    endtask

    task automatic issue(input logic [4:0] rd);
        idle();
        sb_if.issue_valid = 1'b1;
        sb_if.issue_wen   = 1'b1;
        sb_if.issue_rd    = rd;
    endtask

    task automatic wb(input logic [4:0] rd);
        idle();
        sb_if.wb_valid = 1'b1;
        sb_if.wb_rd    = rd;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        idle();
        tick();
        tick();
        for (int i = 0; i < 6; i++) begin
            sb_if.rs1         = 5'($urandom_range(0, 31));
            sb_if.rs2         = 5'($urandom_range(0, 31));
            sb_if.issue_valid = 1'($urandom_range(0, 1));
            sb_if.issue_wen   = 1'($urandom_range(0, 1));
            sb_if.issue_rd    = 5'($urandom_range(0, 31));
            sb_if.wb_valid    = 1'($urandom_range(0, 1));
            sb_if.wb_rd       = 5'($urandom_range(0, 31));
            sb_if.flush       = 1'($urandom_range(0, 1));
            #1;
            n_checks++; if (sb_if.bubble1 !== 1'b0) begin n_fail++; $display("FAIL rst_bubble1: got %b expected 0", sb_if.bubble1); end
            n_checks++; if (sb_if.bubble2 !== 1'b0) begin n_fail++; $display("FAIL rst_bubble2: got %b expected 0", sb_if.bubble2); end
            n_checks++; if (sb_if.issue_ready !== 1'b1) begin n_fail++; $display("FAIL rst_issue_ready: got %b expected 1", sb_if.issue_ready); end
            n_checks++; if (sb_if.n_busy !== 6'd0) begin n_fail++; $display("FAIL rst_n_busy: got %0d expected 0", sb_if.n_busy); end
            n_checks++; if (sb_if.sb_err !== 1'b0) begin n_fail++; $display("FAIL rst_sb_err: got %b expected 0", sb_if.sb_err); end
            tick();
        end
        idle();
        reset = 1'b1;
        #1;
        n_checks++; if (sb_if.bubble1 !== 1'b0 || sb_if.bubble2 !== 1'b0) begin n_fail++; $display("FAIL rel_bubbles: got %b%b expected 00", sb_if.bubble1, sb_if.bubble2); end
        tick();
    endtask

    task automatic test_issue_wb();
        issue(5'd5);
        tick();
        idle();
        sb_if.rs1 = 5'd5;
        #1;
        n_checks++; if (sb_if.bubble1 !== 1'b1) begin n_fail++; $display("FAIL iw_bubble1: got %b expected 1", sb_if.bubble1); end
        n_checks++; if (sb_if.n_busy !== 6'd1) begin n_fail++; $display("FAIL iw_n_busy: got %0d expected 1", sb_if.n_busy); end
        wb(5'd5);
        sb_if.rs1 = 5'd5;
        #1;
        n_checks++; if (sb_if.bubble1 !== 1'b0) begin n_fail++; $display("FAIL iw_bypass: got %b expected 0", sb_if.bubble1); end
        tick();
        idle();
        sb_if.rs1 = 5'd5;
        #1;
        n_checks++; if (sb_if.bubble1 !== 1'b0) begin n_fail++; $display("FAIL iw_cleared: got %b expected 0", sb_if.bubble1); end
        n_checks++; if (sb_if.n_busy !== 6'd0) begin n_fail++; $display("FAIL iw_n_busy_after: got %0d expected 0", sb_if.n_busy); end
    endtask

    task automatic test_rd0();
        for (int i = 0; i < 3; i++) begin
            issue(5'd0);
            #1;
            n_checks++; if (sb_if.issue_ready !== 1'b1) begin n_fail++; $display("FAIL rd0_ready: got %b expected 1", sb_if.issue_ready); end
            tick();
        end
        idle();
        #1;
        n_checks++; if (sb_if.bubble2 !== 1'b0) begin n_fail++; $display("FAIL rd0_bubble2: got %b expected 0", sb_if.bubble2); end
        n_checks++; if (sb_if.n_busy !== 6'd0) begin n_fail++; $display("FAIL rd0_n_busy: got %0d expected 0", sb_if.n_busy); end
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 3; i++) begin
            issue(5'd7);
            #1;
            n_checks++; if (sb_if.issue_ready !== 1'b1) begin n_fail++; $display("FAIL sat_ready_%0d: got %b expected 1", i, sb_if.issue_ready); end
            tick();
        end
        issue(5'd7);
        #1;
        n_checks++; if (sb_if.issue_ready !== 1'b0) begin n_fail++; $display("FAIL sat_full: got %b expected 0", sb_if.issue_ready); end
        tick();
        idle();
        sb_if.issue_wen = 1'b0;
        sb_if.issue_rd  = 5'd7;
        #1;
        n_checks++; if (sb_if.issue_ready !== 1'b1) begin n_fail++; $display("FAIL sat_nowen: got %b expected 1", sb_if.issue_ready); end
        n_checks++; if (sb_if.n_busy !== 6'd1) begin n_fail++; $display("FAIL sat_n_busy: got %0d expected 1", sb_if.n_busy); end
        wb(5'd7);
        tick();
        issue(5'd7);
        sb_if.issue_valid = 1'b0;
        sb_if.rs1 = 5'd7;
        #1;
        n_checks++; if (sb_if.issue_ready !== 1'b1) begin n_fail++; $display("FAIL sat_ready_back: got %b expected 1", sb_if.issue_ready); end
        n_checks++; if (sb_if.bubble1 !== 1'b1) begin n_fail++; $display("FAIL sat_bubble_c2: got %b expected 1", sb_if.bubble1); end
        wb(5'd7);
        tick();
        idle();
        sb_if.rs1 = 5'd7;
        #1;
        n_checks++; if (sb_if.bubble1 !== 1'b1) begin n_fail++; $display("FAIL sat_bubble_c1: got %b expected 1", sb_if.bubble1); end
        wb(5'd7);
        sb_if.rs1 = 5'd7;
        #1;
        n_checks++; if (sb_if.bubble1 !== 1'b0) begin n_fail++; $display("FAIL sat_bypass_last: got %b expected 0", sb_if.bubble1); end
        tick();
        idle();
        sb_if.rs1 = 5'd7;
        #1;
        n_checks++; if (sb_if.bubble1 !== 1'b0) begin n_fail++; $display("FAIL sat_cleared: got %b expected 0", sb_if.bubble1); end
        n_checks++; if (sb_if.n_busy !== 6'd0) begin n_fail++; $display("FAIL sat_n_busy0: got %0d expected 0", sb_if.n_busy); end
        n_checks++; if (sb_if.sb_err !== 1'b0) begin n_fail++; $display("FAIL sat_no_err: got %b expected 0", sb_if.sb_err); end
    endtask

    task automatic test_same_cycle();
        issue(5'd9);
        tick();
        issue(5'd9);
        sb_if.wb_valid = 1'b1;
        sb_if.wb_rd    = 5'd9;
        tick();
        idle();
        sb_if.rs1 = 5'd9;
        #1;
        n_checks++; if (sb_if.bubble1 !== 1'b1) begin n_fail++; $display("FAIL same_bubble: got %b expected 1", sb_if.bubble1); end
        n_checks++; if (sb_if.n_busy !== 6'd1) begin n_fail++; $display("FAIL same_n_busy: got %0d expected 1", sb_if.n_busy); end
        wb(5'd9);
        tick();
        // Issue and retire to an idle register in one cycle: no error, stays idle.
        issue(5'd10);
        sb_if.wb_valid = 1'b1;
        sb_if.wb_rd    = 5'd10;
        tick();
        idle();
        sb_if.rs2 = 5'd10;
        #1;
        n_checks++; if (sb_if.sb_err !== 1'b0) begin n_fail++; $display("FAIL same_zero_err: got %b expected 0", sb_if.sb_err); end
        n_checks++; if (sb_if.bubble2 !== 1'b0) begin n_fail++; $display("FAIL same_zero_bubble: got %b expected 0", sb_if.bubble2); end
        n_checks++; if (sb_if.n_busy !== 6'd0) begin n_fail++; $display("FAIL same_zero_n_busy: got %0d expected 0", sb_if.n_busy); end
        wb(5'd12);
        tick();
        idle();
        #1;
        n_checks++; if (sb_if.sb_err !== 1'b1) begin n_fail++; $display("FAIL err_set: got %b expected 1", sb_if.sb_err); end
        idle();
        sb_if.flush = 1'b1;
        tick();
        idle();
        tick();
        n_checks++; if (sb_if.sb_err !== 1'b1) begin n_fail++; $display("FAIL err_sticky: got %b expected 1", sb_if.sb_err); end
    endtask

    task automatic test_flush();
        issue(5'd3);
        tick();
        issue(5'd4);
        tick();
        idle();
        sb_if.rs1 = 5'd3;
        sb_if.rs2 = 5'd4;
        #1;
        n_checks++; if (sb_if.n_busy !== 6'd2) begin n_fail++; $display("FAIL fl_n_busy2: got %0d expected 2", sb_if.n_busy); end
        n_checks++; if (sb_if.bubble1 !== 1'b1 || sb_if.bubble2 !== 1'b1) begin n_fail++; $display("FAIL fl_busy: got %b%b expected 11", sb_if.bubble1, sb_if.bubble2); end
        issue(5'd6);
        sb_if.flush = 1'b1;
        tick();
        idle();
        sb_if.rs1 = 5'd3;
        sb_if.rs2 = 5'd6;
        #1;
        n_checks++; if (sb_if.n_busy !== 6'd0) begin n_fail++; $display("FAIL fl_n_busy0: got %0d expected 0", sb_if.n_busy); end
        n_checks++; if (sb_if.bubble1 !== 1'b0 || sb_if.bubble2 !== 1'b0) begin n_fail++; $display("FAIL fl_cleared: got %b%b expected 00", sb_if.bubble1, sb_if.bubble2); end
        sb_if.rs1 = 5'd4;
        #1;
        n_checks++; if (sb_if.bubble1 !== 1'b0) begin n_fail++; $display("FAIL fl_reg4: got %b expected 0", sb_if.bubble1); end
    endtask

    task automatic test_back_to_back();
        // Consecutive issues to distinct registers, then a retire alongside a new issue.
        issue(5'd20);
        tick();
        issue(5'd21);
        tick();
        issue(5'd22);
        sb_if.wb_valid = 1'b1;
        sb_if.wb_rd    = 5'd20;
        tick();
        idle();
        sb_if.rs1 = 5'd20;
        sb_if.rs2 = 5'd22;
        #1;
        n_checks++; if (sb_if.n_busy !== 6'd2) begin n_fail++; $display("FAIL b2b_n_busy: got %0d expected 2", sb_if.n_busy); end
        n_checks++; if (sb_if.bubble1 !== 1'b0 || sb_if.bubble2 !== 1'b1) begin n_fail++; $display("FAIL b2b_bubbles: got %b%b expected 01", sb_if.bubble1, sb_if.bubble2); end
        // Asynchronous reset mid-operation drops pending state and the error flag.
        reset = 1'b0;
        #1;
        n_checks++; if (sb_if.n_busy !== 6'd0 || sb_if.sb_err !== 1'b0 || sb_if.bubble2 !== 1'b0) begin n_fail++; $display("FAIL mid_reset: got n_busy=%0d err=%b b2=%b expected 0 0 0", sb_if.n_busy, sb_if.sb_err, sb_if.bubble2); end
        reset = 1'b1;
        tick();
    endtask

    // Test sequence and final report
    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_issue_wb();
        test_rd0();
        test_saturate();
        test_same_cycle();
        test_flush();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
